// File: rtl/req_arbiter_rr.sv
// Registered active-low request arbiter with fixed-priority / round-robin modes and held grants.
// Optional forced release of unacknowledged grants is built when ARB_TIMEOUT_EN is defined.
module req_arbiter_rr #(
    parameter int WIDTH   = 16,
    parameter int IDXW    = $clog2(WIDTH),
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    input  logic             s,
    input  logic             ack,
    output logic [WIDTH-1:0] address,
    output logic [IDXW-1:0]  index,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [IDXW-1:0]  ptr, ptr_nxt, ptr_adv, start, win;
    logic [IDXW-1:0]  index_nxt;
    logic [WIDTH-1:0] address_nxt;
    logic             valid_nxt, timeout_nxt;
    logic [WIDTH-1:0] req;
    logic             done, expire;

    assign req = ~d;

    function automatic logic [IDXW-1:0] lowest(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // Prefer requesters at or above start; otherwise wrap to the lowest one overall.
    function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] v, input logic [IDXW-1:0] st);
        logic [WIDTH-1:0] upper;
        for (int i = 0; i < WIDTH; i++) begin
            upper[i] = v[i] && (i >= int'(st));
        end
        return (|upper) ? lowest(upper) : lowest(v);
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt, cnt_nxt;

    assign expire = (state == GRANT) && !ack && (cnt == CNTW'(TIMEOUT - 1));

    always_comb begin
        cnt_nxt = cnt;
        if (valid_nxt && (state == IDLE || done)) begin
            cnt_nxt = '0;
        end else if (state == GRANT && !done) begin
            cnt_nxt = cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        address_nxt = address;
        index_nxt   = index;
        valid_nxt   = valid;
        timeout_nxt = 1'b0;
        done        = (state == GRANT) && (ack || expire);
        ptr_adv     = (index == IDXW'(WIDTH - 1)) ? '0 : index + IDXW'(1);
        // A completing grant hands the updated pointer straight to a same-edge re-arbitration.
        start       = s ? (done ? ptr_adv : ptr) : '0;
        win         = pick(req, start);
        if (done) ptr_nxt = ptr_adv;

        case (state)
            IDLE: begin
                if (c && |req) begin
                    state_nxt   = GRANT;
                    index_nxt   = win;
                    address_nxt = WIDTH'(1) << win;
                    valid_nxt   = 1'b1;
                end
            end
            GRANT: begin
                if (done) begin
                    timeout_nxt = expire;
                    if (c && |req) begin
                        index_nxt   = win;
                        address_nxt = WIDTH'(1) << win;
                    end else begin
                        state_nxt   = IDLE;
                        index_nxt   = '0;
                        address_nxt = '0;
                        valid_nxt   = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            address <= '0;
            index   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            address <= address_nxt;
            index   <= index_nxt;
            valid   <= valid_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_req_arbiter_rr.sv
// Scoreboard bench for req_arbiter_rr: driver pushes model predictions, monitor pops and compares.
module tb_req_arbiter_rr;

    localparam int W  = 16;
    localparam int IW = $clog2(W);
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk, rst, c, s, ack;
    logic [W-1:0]  d;
    logic [W-1:0]  address;
    logic [IW-1:0] index;
    logic          valid, timeout;

    typedef struct packed {
        logic [W-1:0]  addr;
        logic [IW-1:0] idx;
        logic          vld;
        logic          to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: grant flag, granted line, rotation pointer, unacked cycles.
    bit m_valid;
    int m_idx, m_ptr, m_cnt;
    bit m_to;

    req_arbiter_rr #(.WIDTH(W), .IDXW(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .d(d), .c(c), .s(s), .ack(ack),
        .address(address), .index(index), .valid(valid), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int search(input logic [W-1:0] r, input int first);
        for (int k = 0; k < W; k++) begin
            if (r[(first + k) % W]) return (first + k) % W;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [W-1:0] dv, input logic cv,
                              input logic sv, input logic av);
        bit expired, finished;
        int w;
        if (r) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
            return;
        end
        expired  = m_valid && !av && TO_EN && (m_cnt == TO - 1);
        finished = m_valid && (av || expired);
        m_to = 0;
        if (m_valid && !finished) begin
            m_cnt++;
        end else begin
            if (finished) m_ptr = (m_idx + 1) % W;
            w = search(~dv, sv ? m_ptr : 0);
            if (cv && w >= 0) begin
                m_valid = 1; m_idx = w; m_cnt = 0;
            end else if (finished) begin
                m_valid = 0; m_idx = 0;
            end
            m_to = expired;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.vld  = m_valid;
        e.idx  = m_valid ? IW'(m_idx) : '0;
        e.addr = m_valid ? (W'(1) << m_idx) : '0;
        e.to   = m_to;
        return e;
    endfunction

    task automatic step(input logic r, input logic [W-1:0] dv, input logic cv,
                        input logic sv, input logic av);
        @(negedge clk);
        rst = r; d = dv; c = cv; s = sv; ack = av;
        model_step(r, dv, cv, sv, av);
        q.push_back(predict());
    endtask

    task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare every registered output once per cycle, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("valid",   W'(valid),   W'(e.vld));
                cmp("index",   W'(index),   W'(e.idx));
                cmp("address", address,     e.addr);
                cmp("timeout", W'(timeout), W'(e.to));
            end
        end
    end

    initial begin
        logic [W-1:0] dv;
        logic         rv;
        rst = 1'b1; d = '1; c = 1'b0; s = 1'b0; ack = 1'b0;
        model_step(1'b1, '1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, '1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '1, 1'b0, 1'b0, 1'b0);

        // Fixed priority, then hold while inputs wander.
        step(1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'hFFF0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Round-robin back-to-back.
        repeat (5) step(1'b0, 16'hFFFC, 1'b1, 1'b1, 1'b1);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Wrap-around: line 15 alone, then lines 0 and 15.
        step(1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h7FFE, 1'b1, 1'b1, 1'b1);
        step(1'b0, 16'h7FFE, 1'b1, 1'b1, 1'b1);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Idle with no requests, then ack in IDLE.
        repeat (5) step(1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Pointer moved to 2, line 3 granted, then reset between edges.
        step(1'b0, 16'hFFFD, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'hFFF7, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        cmp("rst_valid",   W'(valid),   '0);
        cmp("rst_index",   W'(index),   '0);
        cmp("rst_address", address,     '0);
        cmp("rst_timeout", W'(timeout), '0);
        step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'hFFF6, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Long unacknowledged grant on line 2 (forced release when the timeout is built).
        step(1'b0, 16'hFFFB, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'hFFF3, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'hFFF3, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       dv = '1;
                1:       dv = ~(W'(1) << $urandom_range(0, W - 1));
                default: dv = ~(W'($urandom) & W'($urandom));
            endcase
            rv = ($urandom_range(0, 249) == 0);
            step(rv, dv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 3));
        end
        step(1'b0, '1, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #3;
        cmp("drain", W'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_arbiter_rr.md
# req_arbiter_rr

Parametrised, registered request arbiter. Samples an active-low request vector `d` on a capture strobe `c` and issues one registered one-hot grant on `address`, plus its binary index. `s` selects fixed-priority or round-robin arbitration. The grant is held until the consumer acknowledges it. Replaces the fixed 16-bit combinational address decoder as the front end of the shared-address path.

## Interface
- `WIDTH`, default 16: number of request lines; must be ≥ 2.
- `IDXW`, default `$clog2(WIDTH)`: width of the index output.
- `TIMEOUT`, default 8: cycles a grant may stay unacknowledged before forced release. Used only with `ARB_TIMEOUT_EN`; must be ≥ 1.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `d`  in  WIDTH: request vector, active-low (bit i = 0 means line i requests).
- `c`  in  1: capture strobe; arbitration happens on an edge where `c` = 1.
- `s`  in  1: mode; 0 = fixed priority (bit 0 highest), 1 = round-robin.
- `ack`  in  1: consumer accepts the current grant.
- `address`  out  WIDTH: one-hot grant, active-high; all zero when no grant.
- `index`  out  IDXW: binary index of the granted line; 0 when no grant.
- `valid`  out  1: grant outstanding.
- `timeout`  out  1: one-cycle pulse on forced release; constant 0 without the macro.

## Operation
- Reset values: `address` = 0, `index` = 0, `valid` = 0, `timeout` = 0, pointer `ptr` = 0, state IDLE, timeout counter = 0.
- Two states: IDLE and GRANT.
- **IDLE → GRANT:** on an edge with `c` = 1 and at least one bit of `d` = 0.
  - Fixed mode (`s` = 0): the lowest-indexed requester wins.
  - Round-robin mode (`s` = 1): the first requester at index ≥ `ptr` wins, searching upward and wrapping from WIDTH-1 to 0.
- **IDLE, no request:** `c` = 1 with `d` all ones leaves the block in IDLE, and outputs are unchanged.
- **GRANT hold:** while `ack` = 0, `address`, `index` and `valid` hold. Changes on `d`, `c` and `s` are ignored.
- **GRANT, `ack` = 1:** the grant completes and `ptr` becomes `(index+1) mod WIDTH`, in both modes.
  - If `c` = 0, or `c` = 1 with no requests: go to IDLE and clear the outputs.
  - If `c` = 1 with a request: re-arbitrate on the same edge, using the updated `ptr` and the current `s`, and stay in GRANT (back-to-back grants).
- `s` is sampled only on an arbitration edge.
- Wrap-around: `ptr` = WIDTH-1 completes to 0.
- Reset asserted mid-grant drops `valid`, `address` and `index` immediately (asynchronously) and returns `ptr` to 0.

## Timing
- Latency: the grant appears on outputs one clock after the capturing edge, i.e. registered and valid after edge N when `c` was high before edge N.
- Release: `valid` falls after the edge that samples `ack` = 1, unless a back-to-back grant replaces it on that edge.
- Minimum grant length is one cycle. Maximum is unbounded without the macro.
- All outputs are driven from flops; there is no combinational input-to-output path.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **With the macro:**
  - A counter clears on each new grant and increments each GRANT cycle in which `ack` = 0.
  - When it reaches TIMEOUT, the grant is released exactly as if acknowledged: `ptr` advances and re-arbitration with `c` is allowed.
  - `timeout` pulses high for one cycle after that edge.
  - If `ack` arrives on the same edge the count would expire, it counts as a normal completion and `timeout` stays 0.
- **Without the macro:** no counter is built, grants hold until `ack`, and `timeout` is tied to 0.

## Test plan
- **Fixed priority:** WIDTH=16, `s`=0, `d`=16'hFFFE, pulse `c` → after one edge `address`=16'h0001, `index`=0, `valid`=1. Outputs hold with `ack`=0 and `d` changed to 16'hFFFF.
- **Round-robin:** `s`=1, `d`=16'hFFFC, `c` held at 1, `ack` held at 1 → successive grants `index` 0, 1, 0, 1 on consecutive cycles, with `valid` never dropping.
- **Wrap-around:** `s`=1, `d`=16'h7FFE.
  - Force `ptr`=15 by granting line 15 alone first.
  - Then `c`+`ack` → next grant is `index`=0, not 15.
- **No request / idle:** `d`=16'hFFFF, `c`=1 for 5 cycles → `valid`=0 and `address`=0 throughout. Then `ack`=1 in IDLE → no effect.
- **Async reset mid-grant:** grant `index`=3, `d`=16'hFFF7, assert `rst` between edges → outputs go to 0 before the next edge. After release, `s`=1 grants from `ptr`=0.
- **Timeout** (with `ARB_TIMEOUT_EN`, TIMEOUT=8): grant `index`=2, hold `ack`=0 → `valid` drops after the 8th GRANT edge, `timeout`=1 for exactly one cycle, `ptr`=3.
